uart_tx: RTL

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_parity_calc.sv | 25 ++
 rtl/uart_tx.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART definitions for the transmitter and receiver
//
// Contents:
//   uart_state_t       - frame FSM state encoding (IDLE, START, DATA, PARITY, STOP)
//   DEFAULT_DATA_WIDTH - payload bits per frame when not overridden
//   PARITY_EVEN/ODD    - encodings of the parity_type input
//   parity_of()        - parity bit for a full 32-bit word, for callers that
//                        need a constant or a scalar helper outside the datapath
package uart_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    function automatic logic parity_of(input logic [31:0] word, input logic ptype);
        return (ptype == PARITY_ODD) ? ~(^word) : ^word;
    endfunction

endpackage

// File: rtl/uart_parity_calc.sv
// rtl/uart_parity_calc.sv - combinational parity generator shared by TX and RX
//
// Ports:
//   data        [DATA_WIDTH-1:0] in  - word to protect
//   parity_type                  in  - 0 = even, 1 = odd
//   parity                       out - bit that makes the total count of ones
//                                      even (even) or odd (odd)
module uart_parity_calc
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  parity_type,
    output logic                  parity
);

    logic data_xor;

    assign data_xor = ^data;

    // Odd parity is the complement of the plain XOR reduction.
    assign parity = (parity_type == PARITY_ODD) ? ~data_xor : data_xor;

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter: start bit, LSB-first data, optional parity, stop bit
//
// Ports:
//   CLK           in  - bit clock, one serial bit per cycle
//   RST           in  - synchronous active-high reset
//   P_DATA        in  - parallel word, valid with Data_Valid
//   Data_Valid    in  - request strobe, only honoured in IDLE
//   parity_enable in  - 1 inserts a parity bit after the data bits
//   parity_type   in  - 0 = even, 1 = odd
//   TX_OUT        out - registered serial line, idles high
//   busy          out - registered, high for every cycle of a frame
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  parity_enable,
    input  logic                  parity_type,
    output logic                  TX_OUT,
    output logic                  busy
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    uart_state_t           state;
    uart_state_t           next_state;
    logic [CNT_W-1:0]      bit_cnt;
    logic [CNT_W-1:0]      bit_cnt_next;
    logic [DATA_WIDTH-1:0] data_reg;
    logic                  par_en_reg;
    logic                  par_bit_reg;
    logic                  par_bit;
    logic                  accept;
    logic                  tx_next;
    logic                  busy_next;

    uart_parity_calc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity_calc (
        .data        (P_DATA),
        .parity_type (parity_type),
        .parity      (par_bit)
    );

    assign accept = (state == IDLE) && Data_Valid;

    // State register. TX_OUT and busy are registered alongside the state so
    // they change on the same edge and have no combinational path from inputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            bit_cnt <= '0;
            TX_OUT  <= 1'b1;
            busy    <= 1'b0;
        end else begin
            state   <= next_state;
            bit_cnt <= bit_cnt_next;
            TX_OUT  <= tx_next;
            busy    <= busy_next;
        end
    end

    // Everything that shapes the frame is frozen at acceptance, so later
    // input changes cannot disturb a frame in flight.
    always_ff @(posedge CLK) begin
        if (RST) begin
            data_reg    <= '0;
            par_en_reg  <= 1'b0;
            par_bit_reg <= 1'b0;
        end else if (accept) begin
            data_reg    <= P_DATA;
            par_en_reg  <= parity_enable;
            par_bit_reg <= par_bit;
        end
    end

    // Next-state logic, including the data bit counter.
    always_comb begin
        next_state   = state;
        bit_cnt_next = '0;
        case (state)
            IDLE: begin
                if (Data_Valid) begin
                    next_state = START;
                end
            end
            START: begin
                next_state = DATA;
            end
            DATA: begin
                if (bit_cnt == LAST_BIT) begin
                    next_state = par_en_reg ? PARITY : STOP;
                end else begin
                    bit_cnt_next = bit_cnt + 1'b1;
                end
            end
            PARITY: begin
                next_state = STOP;
            end
            STOP: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Output logic: the value to appear on the line during the next state.
    // In DATA the serializer mux selects with the next counter value so that
    // bit 0 is on the line in the first DATA cycle.
    always_comb begin
        tx_next   = 1'b1;
        busy_next = 1'b1;
        case (next_state)
            IDLE: begin
                tx_next   = 1'b1;
                busy_next = 1'b0;
            end
            START: begin
                tx_next = 1'b0;
            end
            DATA: begin
                tx_next = data_reg[bit_cnt_next];
            end
            PARITY: begin
                tx_next = par_bit_reg;
            end
            STOP: begin
                tx_next = 1'b1;
            end
            default: begin
                tx_next   = 1'b1;
                busy_next = 1'b0;
            end
        endcase
    end

endmodule
